word_byte_unpacker: RTL

//   Store-side counterpart of the byte/word assembly register: takes one 32-bit word plus size/offset
//   and streams the selected byte lanes out one byte per cycle, little-endian, under valid/ready.

---
 rtl/word_byte_unpacker.sv | 108 ++++++++++
 1 files changed

// File: rtl/word_byte_unpacker.sv
// word_byte_unpacker: streams the byte lanes selected by size/offset out of a
// 32-bit store word, one byte per cycle, little-endian, under valid/ready.
// Misaligned or reserved-size requests are dropped with a one-cycle err pulse.
module word_byte_unpacker #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [1:0]        in_size,
    input  logic [1:0]        in_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic [1:0]        out_lane,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int LANES = WORD_W / BYTE_W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q, state_d;
    logic [WORD_W-1:0]             word_q, word_d;
    logic [1:0]                    lane_q, lane_d;
    logic [2:0]                    rem_q, rem_d;
    logic                          err_q, err_d;
    logic                          legal;
    logic [2:0]                    count;
    logic [LANES-1:0][BYTE_W-1:0]  lanes;

    // Decode request size/offset into byte count and alignment legality.
    always_comb begin
        legal = 1'b0;
        count = 3'd0;
        case (in_size)
            2'b00: begin legal = 1'b1;               count = 3'd1; end
            2'b01: begin legal = ~in_offset[0];      count = 3'd2; end
            2'b10: begin legal = (in_offset == 2'd0); count = 3'd4; end
            default: ;
        endcase
    end

    // Next-state: accept in IDLE, walk lanes in SEND. Lane is not advanced on
    // the final byte so out_byte/out_lane keep showing it after the transfer.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (legal) begin
                        word_d  = in_word;
                        lane_d  = in_offset;
                        rem_d   = count;
                        state_d = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (rem_q == 3'd1) begin
                        state_d = IDLE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                    rem_d = rem_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts a transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= 2'd0;
            rem_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign lanes     = word_q;
    assign in_ready  = (state_q == IDLE) & rst;
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = (state_q == SEND) & (rem_q == 3'd1);
    assign out_byte  = lanes[lane_q];
    assign out_lane  = lane_q;
    assign err       = err_q;
endmodule
